// File: rtl/raster_timing_gen.sv
// Raster scan timing generator: pixel/line counters, syncs, active flag and line/frame strobes.
// Optional frame counter enabled by defining RASTER_FRAME_COUNT_EN.
module raster_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned X_BITS   = 10,
  parameter int unsigned Y_BITS   = 10,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              active,
  output logic              hsync,
  output logic              vsync,
  output logic              new_line,
  output logic              new_frame,
  output logic [7:0]        frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        SYNC_ON  = (SYNC_POL != 0);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic              r_active;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_new_line;
  logic              r_new_frame;

  logic              w_x_end;
  logic              w_y_end;
  logic [X_BITS-1:0] w_x_nxt;
  logic [Y_BITS-1:0] w_y_nxt;
  logic              w_active_nxt;
  logic              w_hsync_nxt;
  logic              w_vsync_nxt;

  // Flags are derived from the next counter values so they line up with x/y.
  always_comb begin
    w_x_end      = (r_x == X_BITS'(H_TOTAL - 1));
    w_y_end      = (r_y == Y_BITS'(V_TOTAL - 1));
    w_x_nxt      = w_x_end ? '0 : r_x + 1'b1;
    w_y_nxt      = r_y;
    if (w_x_end) begin
      w_y_nxt = w_y_end ? '0 : r_y + 1'b1;
    end
    w_active_nxt = (w_x_nxt < X_BITS'(H_ACTIVE)) && (w_y_nxt < Y_BITS'(V_ACTIVE));
    w_hsync_nxt  = ((w_x_nxt >= X_BITS'(HS_START)) && (w_x_nxt < X_BITS'(HS_END)))
                   ? SYNC_ON : ~SYNC_ON;
    w_vsync_nxt  = ((w_y_nxt >= Y_BITS'(VS_START)) && (w_y_nxt < Y_BITS'(VS_END)))
                   ? SYNC_ON : ~SYNC_ON;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= X_BITS'(H_TOTAL - 1);
      r_y         <= Y_BITS'(V_TOTAL - 1);
      r_active    <= 1'b0;
      r_hsync     <= ~SYNC_ON;
      r_vsync     <= ~SYNC_ON;
      r_new_line  <= 1'b0;
      r_new_frame <= 1'b0;
    end else if (en) begin
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_active    <= w_active_nxt;
      r_hsync     <= w_hsync_nxt;
      r_vsync     <= w_vsync_nxt;
      r_new_line  <= w_x_end;
      r_new_frame <= w_x_end && w_y_end;
    end else begin
      r_new_line  <= 1'b0;
      r_new_frame <= 1'b0;
    end
  end

`ifdef RASTER_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (en && w_x_end && w_y_end) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = '0;
`endif

  assign x         = r_x;
  assign y         = r_y;
  assign active    = r_active;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign new_line  = r_new_line;
  assign new_frame = r_new_frame;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Self-checking bench for raster_timing_gen on a shrunken raster, against a linear-position model.
module tb_raster_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;   // 15
  localparam int VT = VA + VFP + VS + VBP;   // 10
  localparam int TOTAL = HT * VT;            // 150
  localparam int POL = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] x;
  logic [3:0] y;
  logic       active, hsync, vsync, new_line, new_frame;
  logic [7:0] frame_count;

  int n_vec = 0;
  int n_bad = 0;

  // Model: raster position as a single linear pixel index.
  int p = TOTAL - 1;
  int fc = 0;
  bit e_nl = 0, e_nf = 0;

  raster_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .X_BITS(4), .Y_BITS(4), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
    .new_line(new_line), .new_frame(new_frame), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int ex, ey, efc;
    ex = p % HT;
    ey = p / HT;
`ifdef RASTER_FRAME_COUNT_EN
    efc = fc;
`else
    efc = 0;
`endif
    chk("x", 32'(x), 32'(ex));
    chk("y", 32'(y), 32'(ey));
    chk("active", 32'(active), 32'(ex < HA && ey < VA));
    chk("hsync", 32'(hsync), 32'((ex >= HA + HFP && ex < HA + HFP + HS) ? POL : 1 - POL));
    chk("vsync", 32'(vsync), 32'((ey >= VA + VFP && ey < VA + VFP + VS) ? POL : 1 - POL));
    chk("new_line", 32'(new_line), 32'(e_nl));
    chk("new_frame", 32'(new_frame), 32'(e_nf));
    chk("frame_count", 32'(frame_count), 32'(efc));
  endtask

  task automatic apply(input bit rst, input bit e);
    reset = rst;
    en = e;
    @(posedge clk);
    if (rst) begin
      p = TOTAL - 1; e_nl = 0; e_nf = 0; fc = 0;
    end else if (e) begin
      p = (p + 1) % TOTAL;
      e_nl = (p % HT == 0);
      e_nf = (p == 0);
      if (e_nf) fc = (fc + 1) % 256;
    end else begin
      e_nl = 0; e_nf = 0;
    end
    #1 check_all();
  endtask

  initial begin
    int n_act, n_hs, n_vs, n_nl, n_nf;

    // Reset for 3 clocks, then the first step lands on 0,0 with both strobes.
    repeat (3) apply(1, 1);
    chk("rst_x", 32'(x), HT - 1);
    chk("rst_y", 32'(y), VT - 1);
    apply(0, 1);
    chk("first_nf", 32'(new_frame), 1);
    chk("first_act", 32'(active), 1);
    apply(0, 1);
    chk("second_x", 32'(x), 1);
    chk("second_nl", 32'(new_line), 0);

    // One full frame from x=0,y=0 with aggregate line/frame counts.
    apply(1, 0);
    n_act = 0; n_hs = 0; n_vs = 0; n_nl = 0; n_nf = 0;
    for (int i = 0; i < TOTAL; i++) begin
      apply(0, 1);
      if (i < HT) begin
        n_act += int'(active);
        n_hs  += int'(hsync == 1'(POL));
      end
      n_vs += int'(vsync == 1'(POL));
      n_nl += int'(new_line);
      n_nf += int'(new_frame);
    end
    chk("line_active_cnt", 32'(n_act), HA);
    chk("line_hsync_cnt", 32'(n_hs), HS);
    chk("frame_vsync_cnt", 32'(n_vs), VS * HT);
    chk("frame_nl_cnt", 32'(n_nl), VT);
    chk("frame_nf_cnt", 32'(n_nf), 1);

    // Alternating enable: two frames need four frames' worth of clocks.
    n_nf = 0;
    for (int i = 0; i < 2 * TOTAL; i++) begin
      apply(0, 1);
      n_nf += int'(new_frame);
      apply(0, 0);
      n_nf += int'(new_frame);
    end
    chk("toggle_nf_cnt", 32'(n_nf), 2);

    // Reset mid-frame at x=5,y=4.
    for (int i = 0; i < TOTAL && !(p % HT == 5 && p / HT == 4); i++) apply(0, 1);
    chk("mid_pos", 32'(p), 4 * HT + 5);
    apply(1, 1);
    chk("mid_rst_x", 32'(x), HT - 1);
    chk("mid_rst_active", 32'(active), 0);
    apply(0, 1);
    chk("mid_rel_nf", 32'(new_frame), 1);

    // Randomized enable with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      apply(($urandom % 300) == 0, ($urandom % 4) != 0);
    end

    // 257 frames: frame_count wraps through 255 -> 0 -> 1.
    apply(1, 0);
    for (int i = 0; i < 257 * TOTAL + 2; i++) apply(0, 1);
`ifdef RASTER_FRAME_COUNT_EN
    chk("fc_after_257", 32'(frame_count), 2);
`else
    chk("fc_after_257", 32'(frame_count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/raster_timing_gen.md
Name: raster_timing_gen

Overview:
- Generates the raster scan that drives the demo pipeline: pixel/line counters, hsync, vsync, active-video flag, and new_line/new_frame strobes.
- Sits directly upstream of the demo renderer and the pad-output stage. The renderer uses x/y/active to produce rgb222. The output stage registers hsync/vsync alongside the pixel data.
- Defaults give 640x480@60 timing at a ~25.2 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- X_BITS, 10, width of x counter; must hold H_TOTAL-1
- Y_BITS, 10, width of y counter; must hold V_TOTAL-1
- SYNC_POL, 0, asserted sync level (0 = active-low, 1 = active-high)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- en  input  1  pixel-step enable; counters advance only when 1
- x  output  X_BITS  current pixel column
- y  output  Y_BITS  current line
- active  output  1  1 when x<H_ACTIVE and y<V_ACTIVE
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- new_line  output  1  one-clk strobe on entering x=0
- new_frame  output  1  one-clk strobe on entering x=0,y=0
- frame_count  output  8  frame counter (see Optional Feature)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Output timing: all outputs are registered. Each output is computed from the next-state counter values, so within a cycle active/hsync/vsync always describe the current x,y. There is no extra latency between x,y and the flags.
- Reset (sampled high on a clk edge):
  - x=H_TOTAL-1, y=V_TOTAL-1 (last pixel of the frame, in back porch).
  - active=0; hsync=vsync=!SYNC_POL (deasserted).
  - new_line=0, new_frame=0, frame_count=0.
  - Reset overrides en.
- Stepping, on a clk edge with reset=0 and en=1:
  - x<H_TOTAL-1: x<=x+1.
  - Otherwise: x<=0, and y<=(y==V_TOTAL-1)?0:y+1.
- First step after reset release lands on x=0,y=0 with active=1, new_line=1, new_frame=1.
- Holding, on a clk edge with reset=0 and en=0:
  - x, y, active, hsync, vsync, frame_count hold their values.
  - new_line and new_frame drop to 0.
- Strobes:
  - new_line=1 for exactly the one clk cycle after a step into x=0.
  - new_frame=1 only when that step also enters y=0.
  - Both strobes are 0 on every other cycle, including held cycles.
- hsync asserted (=SYNC_POL) iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (defaults: 656..751).
- vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (defaults: 490..491). vsync edges coincide with x=0.
- Counter comparisons are unsigned. No counter ever exceeds its TOTAL-1.
- Reset mid-frame: the next cycle shows the reset values regardless of position, and the raster restarts cleanly from 0,0.

Optional Feature:
- Macro: RASTER_FRAME_COUNT_EN.
- Defined: frame_count increments by 1 on every step into x=0,y=0, i.e. the same cycle new_frame rises. It wraps 255->0 and resets to 0. The renderer uses it for animation time.
- Undefined: frame_count is constant 0 and no counter register is instantiated. The port is still present.

Test Plan:
- Reset for 3 clks, release, en=1 -> first cycle after release: x=0, y=0, active=1, new_line=1, new_frame=1. Next cycle: x=1, both strobes 0.
- One full line, defaults -> active high for exactly 640 cycles; hsync low exactly for x=656..751 (96 cycles); new_line period 800 clks.
- One full frame, defaults -> vsync low exactly for 1600 clks (y=490..491); new_frame period 420000 clks; active=0 for all y>=480.
- en toggling 1,0,1,0 -> x advances every second clk; strobes are 1 clk wide and never repeat during hold; new_frame period 840000 clks.
- Reset asserted at x=300, y=200 -> next cycle x=799, y=524, active=0, syncs deasserted; after release the next cycle is x=0, y=0 with new_frame=1.
- With RASTER_FRAME_COUNT_EN, run 257 frames -> frame_count reads 255 then 0 then 1 at successive new_frame pulses. Without the macro -> frame_count=0 throughout.
